// File: rtl/dram_burst_sequencer_pkg.sv
// Shared widths and command FSM encoding for the DRAM burst sequencer slice.
package dram_burst_sequencer_pkg;

   localparam int unsigned DRAM_BEAT_W = 144;
   localparam int unsigned DRAM_BE_W   = 18;
   localparam int unsigned USR_DATA_W  = 288;
   localparam int unsigned USR_BE_W    = 36;
   localparam int unsigned CMD_TAG_W   = 32;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR_LO,
      WR_HI
   } cmd_state_t;

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order read tag FIFO: first-word-fall-through, distributed RAM storage.
module dram_tag_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic             Mem_Clk,
   input  logic             Mem_Rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a pop frees the head slot in the same cycle, so push-while-full is accepted then
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge Mem_Clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge Mem_Clk or negedge Mem_Rst_n) begin
      if (!Mem_Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/dram_burst_sequencer.sv
// Splits 288-bit user requests into 144-bit bridge command beats and rebuilds
// 288-bit read responses, tagging them from an in-order tag FIFO.
module dram_burst_sequencer
   import dram_burst_sequencer_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 16,
   parameter int unsigned TAG_W           = 32
) (
   input  logic                   Mem_Clk,
   input  logic                   Mem_Rst_n,
   input  logic                   usr_valid,
   output logic                   usr_ready,
   input  logic                   usr_rnw,
   input  logic [31:0]            usr_address,
   input  logic [USR_DATA_W-1:0]  usr_data,
   input  logic [USR_BE_W-1:0]    usr_be,
   input  logic [TAG_W-1:0]       usr_tag,
   output logic [31:0]            Mem_Cmd_Address,
   output logic                   Mem_Cmd_RNW,
   output logic                   Mem_Cmd_Valid,
   input  logic                   Mem_Cmd_Ack,
   output logic [CMD_TAG_W-1:0]   Mem_Cmd_Tag,
   output logic [DRAM_BEAT_W-1:0] Mem_Wr_Din,
   output logic [DRAM_BE_W-1:0]   Mem_Wr_BE,
   input  logic [DRAM_BEAT_W-1:0] Mem_Rd_Dout,
   input  logic                   Mem_Rd_Valid,
   output logic                   Mem_Rd_Ack,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [USR_DATA_W-1:0]  rsp_data,
   output logic [TAG_W-1:0]       rsp_tag,
   output logic                   err_unexpected_rd
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   cmd_state_t             state;
   logic [DRAM_BEAT_W-1:0] cap_data_hi;
   logic [DRAM_BE_W-1:0]   cap_be_hi;
   logic [TAG_W-1:0]       cap_tag;
   logic [CMD_TAG_W-1:0]   usr_tag_ext;

   logic [CNT_W-1:0]       outstanding;
   logic [CNT_W:0]         committed;
   logic                   beat;
   logic [DRAM_BEAT_W-1:0] rd_low;

   logic                   fin;
   logic                   rd_full;
   logic                   accept;
   logic                   issue_rd;
   logic                   stray;
   logic                   complete;
   logic                   tag_full;
   logic                   tag_empty;
   logic [TAG_W-1:0]       tag_head;

   generate
      if (TAG_W >= CMD_TAG_W) begin : g_tag_trunc
         assign usr_tag_ext = usr_tag[CMD_TAG_W-1:0];
      end else begin : g_tag_zext
         assign usr_tag_ext = {{(CMD_TAG_W - TAG_W){1'b0}}, usr_tag};
      end
   endgenerate

   assign fin      = Mem_Cmd_Ack && (state == RD || state == WR_HI);
   assign issue_rd = Mem_Cmd_Ack && (state == RD);
   // a read still sitting in RD already owns a slot even though it is not yet counted
   assign committed = {1'b0, outstanding} + {{CNT_W{1'b0}}, (state == RD)};
   assign rd_full   = (committed >= (CNT_W + 1)'(MAX_OUTSTANDING)) || tag_full;
   assign usr_ready = (state == IDLE || fin) && !(usr_rnw && rd_full);
   assign accept    = usr_valid && usr_ready;

   assign stray      = Mem_Rd_Valid && !beat && (outstanding == '0);
   assign Mem_Rd_Ack = beat ? (Mem_Rd_Valid && (!rsp_valid || rsp_ready)) : Mem_Rd_Valid;
   assign complete   = beat && Mem_Rd_Ack;

   always_ff @(posedge Mem_Clk or negedge Mem_Rst_n) begin
      if (!Mem_Rst_n) begin
         state           <= IDLE;
         Mem_Cmd_Valid   <= 1'b0;
         Mem_Cmd_Address <= '0;
         Mem_Cmd_RNW     <= 1'b0;
         Mem_Cmd_Tag     <= '0;
         Mem_Wr_Din      <= '0;
         Mem_Wr_BE       <= '0;
         cap_data_hi     <= '0;
         cap_be_hi       <= '0;
         cap_tag         <= '0;
      end else if (accept) begin
         state           <= usr_rnw ? RD : WR_LO;
         Mem_Cmd_Valid   <= 1'b1;
         Mem_Cmd_Address <= usr_address;
         Mem_Cmd_RNW     <= usr_rnw;
         Mem_Cmd_Tag     <= usr_tag_ext;
         Mem_Wr_Din      <= usr_data[DRAM_BEAT_W-1:0];
         Mem_Wr_BE       <= usr_be[DRAM_BE_W-1:0];
         cap_data_hi     <= usr_data[USR_DATA_W-1:DRAM_BEAT_W];
         cap_be_hi       <= usr_be[USR_BE_W-1:DRAM_BE_W];
         cap_tag         <= usr_tag;
      end else if (state == WR_LO && Mem_Cmd_Ack) begin
         state      <= WR_HI;
         Mem_Wr_Din <= cap_data_hi;
         Mem_Wr_BE  <= cap_be_hi;
      end else if (fin) begin
         state         <= IDLE;
         Mem_Cmd_Valid <= 1'b0;
      end
   end

   always_ff @(posedge Mem_Clk or negedge Mem_Rst_n) begin
      if (!Mem_Rst_n) begin
         beat              <= 1'b0;
         rd_low            <= '0;
         rsp_valid         <= 1'b0;
         rsp_data          <= '0;
         rsp_tag           <= '0;
         outstanding       <= '0;
         err_unexpected_rd <= 1'b0;
      end else begin
         if (Mem_Rd_Valid && !beat) begin
            if (stray) begin
               err_unexpected_rd <= 1'b1;
            end else begin
               rd_low <= Mem_Rd_Dout;
               beat   <= 1'b1;
            end
         end
         if (complete) begin
            rsp_data  <= {Mem_Rd_Dout, rd_low};
            rsp_tag   <= tag_head;
            rsp_valid <= 1'b1;
            beat      <= 1'b0;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         case ({issue_rd, complete})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   dram_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TAG_W)
   ) u_tag_fifo (
      .Mem_Clk   (Mem_Clk),
      .Mem_Rst_n (Mem_Rst_n),
      .push      (issue_rd),
      .push_data (cap_tag),
      .pop       (complete),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   logic unused_ok;
   assign unused_ok = tag_empty;

endmodule

// File: tb/tb_dram_burst_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_dram_burst_sequencer;

   logic          Mem_Clk;
   logic          Mem_Rst_n;
   logic          usr_valid;
   logic          usr_ready;
   logic          usr_rnw;
   logic [31:0]   usr_address;
   logic [287:0]  usr_data;
   logic [35:0]   usr_be;
   logic [31:0]   usr_tag;
   logic [31:0]   Mem_Cmd_Address;
   logic          Mem_Cmd_RNW;
   logic          Mem_Cmd_Valid;
   logic          Mem_Cmd_Ack;
   logic [31:0]   Mem_Cmd_Tag;
   logic [143:0]  Mem_Wr_Din;
   logic [17:0]   Mem_Wr_BE;
   logic [143:0]  Mem_Rd_Dout;
   logic          Mem_Rd_Valid;
   logic          Mem_Rd_Ack;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [287:0]  rsp_data;
   logic [31:0]   rsp_tag;
   logic          err_unexpected_rd;

   dram_burst_sequencer #(
      .MAX_OUTSTANDING (16),
      .TAG_W           (32)
   ) dut (
      .Mem_Clk           (Mem_Clk),
      .Mem_Rst_n         (Mem_Rst_n),
      .usr_valid         (usr_valid),
      .usr_ready         (usr_ready),
      .usr_rnw           (usr_rnw),
      .usr_address       (usr_address),
      .usr_data          (usr_data),
      .usr_be            (usr_be),
      .usr_tag           (usr_tag),
      .Mem_Cmd_Address   (Mem_Cmd_Address),
      .Mem_Cmd_RNW       (Mem_Cmd_RNW),
      .Mem_Cmd_Valid     (Mem_Cmd_Valid),
      .Mem_Cmd_Ack       (Mem_Cmd_Ack),
      .Mem_Cmd_Tag       (Mem_Cmd_Tag),
      .Mem_Wr_Din        (Mem_Wr_Din),
      .Mem_Wr_BE         (Mem_Wr_BE),
      .Mem_Rd_Dout       (Mem_Rd_Dout),
      .Mem_Rd_Valid      (Mem_Rd_Valid),
      .Mem_Rd_Ack        (Mem_Rd_Ack),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_data          (rsp_data),
      .rsp_tag           (rsp_tag),
      .err_unexpected_rd (err_unexpected_rd)
   );

   initial begin
      Mem_Clk = 1'b0;
      forever #5 Mem_Clk = ~Mem_Clk;
   end

   typedef struct {
      logic [31:0]  addr;
      logic         rnw;
      logic [143:0] data;
      logic [17:0]  be;
      logic [31:0]  tag;
   } cmd_t;

   typedef struct {
      logic [287:0] data;
      logic [31:0]  tag;
   } rsp_t;

   cmd_t         exp_cmd_q[$];
   rsp_t         exp_rsp_q[$];
   logic [143:0] ret_q[$];

   int   checks = 0;
   int   errors = 0;
   int   ack_mode;     // 0 random, 1 high, 2 low
   int   rsp_mode;     // 0 random, 1 high, 2 low
   int   ret_pct;
   bit   ret_en;
   bit   junk_req;
   bit   junk_active;
   bit   rd_consumed;
   bit   exp_err;

   task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [143:0] rnd144();
      return 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
   endfunction

   // monitor / reference model
   cmd_t         h;
   rsp_t         r;
   logic [143:0] b0, b1;

   always @(negedge Mem_Clk) begin
      if (Mem_Rst_n) begin
         check("err_flag", 288'(err_unexpected_rd), 288'(exp_err));
         check("rd_ack_without_valid", 288'(Mem_Rd_Ack & ~Mem_Rd_Valid), 288'(0));
         if (Mem_Cmd_Valid) begin
            if (exp_cmd_q.size() == 0) begin
               check("cmd_unexpected", 288'(Mem_Cmd_Valid), 288'(0));
            end else begin
               h = exp_cmd_q[0];
               check("cmd_addr", 288'(Mem_Cmd_Address), 288'(h.addr));
               check("cmd_rnw", 288'(Mem_Cmd_RNW), 288'(h.rnw));
               check("cmd_tag", 288'(Mem_Cmd_Tag), 288'(h.tag));
               if (!h.rnw) begin
                  check("cmd_wr_data", 288'(Mem_Wr_Din), 288'(h.data));
                  check("cmd_wr_be", 288'(Mem_Wr_BE), 288'(h.be));
               end
               if (Mem_Cmd_Ack) begin
                  void'(exp_cmd_q.pop_front());
                  if (h.rnw) begin
                     b0 = rnd144();
                     b1 = rnd144();
                     ret_q.push_back(b0);
                     ret_q.push_back(b1);
                     r.data = {b1, b0};
                     r.tag  = h.tag;
                     exp_rsp_q.push_back(r);
                  end
               end
            end
         end
         if (usr_valid && usr_ready) begin
            h.addr = usr_address;
            h.rnw  = usr_rnw;
            h.tag  = usr_tag;
            h.data = usr_data[143:0];
            h.be   = usr_be[17:0];
            exp_cmd_q.push_back(h);
            if (!usr_rnw) begin
               h.data = usr_data[287:144];
               h.be   = usr_be[35:18];
               exp_cmd_q.push_back(h);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
               check("rsp_unexpected", 288'(rsp_valid), 288'(0));
            end else begin
               r = exp_rsp_q.pop_front();
               check("rsp_data", rsp_data, r.data);
               check("rsp_tag", 288'(rsp_tag), 288'(r.tag));
            end
         end
         if (Mem_Rd_Valid && Mem_Rd_Ack) begin
            rd_consumed = 1'b1;
            if (junk_active) exp_err = 1'b1;
         end
      end
   end

   // bridge and response-consumer driver
   initial begin
      Mem_Cmd_Ack  = 1'b0;
      Mem_Rd_Valid = 1'b0;
      Mem_Rd_Dout  = '0;
      rsp_ready    = 1'b0;
      forever begin
         @(posedge Mem_Clk);
         #1;
         Mem_Cmd_Ack = (ack_mode == 0) ? ($urandom_range(3) != 0) : (ack_mode == 1);
         rsp_ready   = (rsp_mode == 0) ? ($urandom_range(2) != 0) : (rsp_mode == 1);
         if (rd_consumed) begin
            rd_consumed = 1'b0;
            if (junk_active) junk_active = 1'b0;
            else if (ret_q.size() > 0) void'(ret_q.pop_front());
         end
         if (!junk_active) begin
            if (ret_en && ret_q.size() > 0 && $urandom_range(99) < ret_pct) begin
               Mem_Rd_Valid = 1'b1;
               Mem_Rd_Dout  = ret_q[0];
            end else if (junk_req && ret_q.size() == 0) begin
               junk_req     = 1'b0;
               junk_active  = 1'b1;
               Mem_Rd_Valid = 1'b1;
               Mem_Rd_Dout  = rnd144();
            end else begin
               Mem_Rd_Valid = 1'b0;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Mem_Clk);
         #1;
      end
   endtask

   task automatic issue(input logic rnw, input logic [31:0] a, input logic [287:0] d,
                        input logic [35:0] be, input logic [31:0] tag);
      bit ok = 1'b0;
      usr_valid   = 1'b1;
      usr_rnw     = rnw;
      usr_address = a;
      usr_data    = d;
      usr_be      = be;
      usr_tag     = tag;
      for (int i = 0; i < 500; i++) begin
         @(negedge Mem_Clk);
         if (usr_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge Mem_Clk);
      #1;
      usr_valid = 1'b0;
      if (!ok) check("issue_timeout", 288'(ok), 288'(1));
   endtask

   task automatic drain(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge Mem_Clk);
         if (exp_cmd_q.size() == 0 && ret_q.size() == 0 && exp_rsp_q.size() == 0 &&
             !Mem_Cmd_Valid && !rsp_valid) begin
            done = 1'b1;
            break;
         end
      end
      check({"drain_", tag}, 288'(done), 288'(1));
      @(posedge Mem_Clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   logic [143:0] pat_a, pat_b, pat_c, pat_d;
   bit           hit;

   initial begin
      pat_a = {36{4'hA}};
      pat_b = {36{4'hB}};
      pat_c = {36{4'hC}};
      pat_d = {36{4'hD}};
      usr_valid = 1'b0; usr_rnw = 1'b0; usr_address = '0; usr_data = '0; usr_be = '0; usr_tag = '0;
      ack_mode = 1; rsp_mode = 1; ret_pct = 100; ret_en = 1'b1;
      junk_req = 1'b0; junk_active = 1'b0; rd_consumed = 1'b0; exp_err = 1'b0;
      Mem_Rst_n = 1'b0;
      repeat (3) @(posedge Mem_Clk);
      @(negedge Mem_Clk);
      check("rst_cmd_valid", 288'(Mem_Cmd_Valid), 288'(0));
      check("rst_rsp_valid", 288'(rsp_valid), 288'(0));
      check("rst_err", 288'(err_unexpected_rd), 288'(0));
      check("rst_addr", 288'(Mem_Cmd_Address), 288'(0));
      check("rst_wr_din", 288'(Mem_Wr_Din), 288'(0));
      check("rst_rsp_data", rsp_data, 288'(0));
      check("rst_usr_ready", 288'(usr_ready), 288'(1));
      @(posedge Mem_Clk);
      #1;
      Mem_Rst_n = 1'b1;
      step(1);

      // write pair timing with Ack held high
      issue(1'b0, 32'h100, {pat_b, pat_a}, '1, 32'h11);
      @(negedge Mem_Clk);
      check("wr_b0_valid", 288'(Mem_Cmd_Valid), 288'(1));
      check("wr_b0_rnw", 288'(Mem_Cmd_RNW), 288'(0));
      check("wr_b0_addr", 288'(Mem_Cmd_Address), 288'(32'h100));
      check("wr_b0_data", 288'(Mem_Wr_Din), 288'(pat_a));
      check("wr_b0_be", 288'(Mem_Wr_BE), 288'(18'h3FFFF));
      check("wr_b0_usr_ready", 288'(usr_ready), 288'(0));
      @(negedge Mem_Clk);
      check("wr_b1_addr", 288'(Mem_Cmd_Address), 288'(32'h100));
      check("wr_b1_data", 288'(Mem_Wr_Din), 288'(pat_b));
      drain("wr_pair");

      // second write beat stalled for 3 cycles with a read queued behind it
      usr_valid = 1'b1; usr_rnw = 1'b0; usr_address = 32'h140;
      usr_data = {pat_c, pat_d}; usr_be = 36'h0_1234_5678; usr_tag = 32'h22;
      @(negedge Mem_Clk);
      check("stall_wr_ready", 288'(usr_ready), 288'(1));
      @(posedge Mem_Clk);
      #1;
      usr_rnw = 1'b1; usr_address = 32'h300; usr_tag = 32'h55;
      @(negedge Mem_Clk);
      check("stall_rd_blocked_lo", 288'(usr_ready), 288'(0));
      ack_mode = 2;
      for (int i = 0; i < 3; i++) begin
         @(negedge Mem_Clk);
         check("stall_hi_valid", 288'(Mem_Cmd_Valid), 288'(1));
         check("stall_hi_rnw", 288'(Mem_Cmd_RNW), 288'(0));
         check("stall_hi_data", 288'(Mem_Wr_Din), 288'(pat_c));
         check("stall_rd_blocked_hi", 288'(usr_ready), 288'(0));
      end
      ack_mode = 1;
      @(negedge Mem_Clk);
      check("stall_rd_ready_on_fin", 288'(usr_ready), 288'(1));
      @(posedge Mem_Clk);
      #1;
      usr_valid = 1'b0;
      @(negedge Mem_Clk);
      check("stall_rd_issued_rnw", 288'(Mem_Cmd_RNW), 288'(1));
      check("stall_rd_issued_addr", 288'(Mem_Cmd_Address), 288'(32'h300));
      drain("stall");

      // fill all 16 read slots, 17th must stall until a response frees one
      ret_en = 1'b0;
      for (int i = 0; i < 16; i++) issue(1'b1, 32'h1000 + 32'(i * 4), '0, '0, 32'(i));
      usr_valid = 1'b1; usr_rnw = 1'b1; usr_address = 32'h2000; usr_tag = 32'd16;
      for (int i = 0; i < 4; i++) begin
         @(negedge Mem_Clk);
         check("full_17th_stalled", 288'(usr_ready), 288'(0));
      end
      ret_en = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge Mem_Clk);
         if (usr_ready) begin
            hit = 1'b1;
            check("full_first_rsp_valid", 288'(rsp_valid), 288'(1));
            check("full_first_rsp_tag", 288'(rsp_tag), 288'(0));
            break;
         end
      end
      check("full_17th_accepted", 288'(hit), 288'(1));
      @(posedge Mem_Clk);
      #1;
      usr_valid = 1'b0;
      drain("full");

      // consumer back-pressure across two completions
      rsp_mode = 2;
      issue(1'b1, 32'h400, '0, '0, 32'hA0);
      issue(1'b1, 32'h404, '0, '0, 32'hA1);
      repeat (20) @(negedge Mem_Clk);
      check("bp_rsp_valid", 288'(rsp_valid), 288'(1));
      check("bp_rsp_tag", 288'(rsp_tag), 288'(32'hA0));
      check("bp_rd_valid", 288'(Mem_Rd_Valid), 288'(1));
      check("bp_rd_ack_withheld", 288'(Mem_Rd_Ack), 288'(0));
      check("bp_beats_left", 288'(ret_q.size()), 288'(1));
      rsp_mode = 1;
      drain("bp");

      // stray read beat with nothing outstanding
      @(negedge Mem_Clk);
      junk_req = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Mem_Clk);
         if (exp_err) begin
            hit = 1'b1;
            break;
         end
      end
      check("stray_consumed", 288'(hit), 288'(1));
      repeat (3) @(negedge Mem_Clk);
      check("stray_err_sticky", 288'(err_unexpected_rd), 288'(1));
      check("stray_no_rsp", 288'(rsp_valid), 288'(0));

      // randomized traffic
      ack_mode = 0; rsp_mode = 0; ret_pct = 60;
      step(1);
      for (int i = 0; i < 250; i++) begin
         step($urandom_range(2));
         issue(1'($urandom_range(1)), $urandom, {rnd144(), rnd144()},
               36'({$urandom, $urandom}), $urandom);
      end
      @(negedge Mem_Clk);
      rsp_mode = 1;
      ret_pct = 100;
      drain("random");

      // reset between the two write beats, with reads outstanding
      ack_mode = 1; ret_en = 1'b0;
      for (int i = 0; i < 3; i++) issue(1'b1, 32'h500 + 32'(i), '0, '0, 32'hB0 + 32'(i));
      step(2);
      @(negedge Mem_Clk);
      ack_mode = 2;
      @(posedge Mem_Clk);
      #1;
      issue(1'b0, 32'h180, {pat_a, pat_b}, '1, 32'h66);
      @(negedge Mem_Clk);
      check("mid_wr_lo_valid", 288'(Mem_Cmd_Valid), 288'(1));
      #2;
      Mem_Rst_n = 1'b0;
      exp_cmd_q.delete();
      exp_rsp_q.delete();
      ret_q.delete();
      rd_consumed = 1'b0;
      exp_err = 1'b0;
      #1;
      check("mid_rst_cmd_valid", 288'(Mem_Cmd_Valid), 288'(0));
      check("mid_rst_addr", 288'(Mem_Cmd_Address), 288'(0));
      check("mid_rst_err", 288'(err_unexpected_rd), 288'(0));
      @(negedge Mem_Clk);
      ack_mode = 1;
      ret_en = 1'b1;
      @(posedge Mem_Clk);
      #1;
      Mem_Rst_n = 1'b1;
      step(1);
      issue(1'b1, 32'h200, '0, '0, 32'h77);
      @(negedge Mem_Clk);
      check("post_rst_valid", 288'(Mem_Cmd_Valid), 288'(1));
      check("post_rst_rnw", 288'(Mem_Cmd_RNW), 288'(1));
      check("post_rst_addr", 288'(Mem_Cmd_Address), 288'(32'h200));
      drain("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
